qeciphy_resetwatchdog: RTL

QECIPHY_RESETWATCHDOG -- requirements
Module: qeciphy_resetwatchdog

---
 rtl/qeciphy_pkg.sv | 25 ++
 rtl/riv_counter.sv | 31 +++
 rtl/qeciphy_resetwatchdog.sv | 127 ++++++++++++
 3 files changed

// File: rtl/qeciphy_pkg.sv
// -----------------------------------------------------------------------------
// qeciphy_pkg
// Shared types and constants for the QECIPHY reset watchdog.
//   wd_state_e   : watchdog state encoding; ST_RSVD is never entered on purpose
//                  and is handled as ASSERT if a state upset ever lands on it.
//   WD_CNT_W     : width of the shared pulse/timeout counter.
//   sat_inc8()   : saturating 8-bit increment used by the fault counter.
// -----------------------------------------------------------------------------
package qeciphy_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_RUN       = 3'd2,
    ST_FAILED    = 3'd3,
    ST_RSVD      = 3'd7
  } wd_state_e;

  localparam int WD_CNT_W = 24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/riv_counter.sv
// -----------------------------------------------------------------------------
// riv_counter
// Free-running up-counter with synchronous clear, used to time both the reset
// pulse and the reset-done timeout.
//   clk   : clock
//   rst   : synchronous active-high reset, forces count to zero
//   clr   : synchronous reload to zero (takes priority over en)
//   en    : count enable
//   count : current count value
// -----------------------------------------------------------------------------
module riv_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/qeciphy_resetwatchdog.sv
// -----------------------------------------------------------------------------
// qeciphy_resetwatchdog
// Drives the active-low master reset of the QECIPHY reset controller, retries
// bring-up on timeout, re-resets on link loss and gives up after MAX_RETRIES
// consecutive timeouts until the user asks again.
//   axis_clk        : single clock
//   axis_rst        : synchronous active-high reset
//   i_user_rst_req  : level-sensitive user reset request (highest priority)
//   i_reset_done    : bring-up complete from the reset controller
//   i_link_fault    : link loss from downstream PHY logic
//   o_ctrl_rst_n    : active-low reset to the reset controller
//   o_busy          : in ASSERT or WAIT_DONE
//   o_failed        : in FAILED
//   o_retry_count   : timed-out attempts since last request / good bring-up
//   o_fault_count   : link faults seen in RUN, saturating at 255
// -----------------------------------------------------------------------------
module qeciphy_resetwatchdog
  import qeciphy_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES   = 1048576,
  parameter int MAX_RETRIES      = 4
) (
  input  logic       axis_clk,
  input  logic       axis_rst,
  input  logic       i_user_rst_req,
  input  logic       i_reset_done,
  input  logic       i_link_fault,
  output logic       o_ctrl_rst_n,
  output logic       o_busy,
  output logic       o_failed,
  output logic [3:0] o_retry_count,
  output logic [7:0] o_fault_count
);

  localparam logic [WD_CNT_W-1:0] PULSE_LAST   = WD_CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [WD_CNT_W-1:0] TIMEOUT_LAST = WD_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]          RETRY_LIMIT  = 4'(MAX_RETRIES);

  wd_state_e           state;
  wd_state_e           state_nx;
  logic [3:0]          retry_nx;
  logic [7:0]          fault_nx;
  logic [WD_CNT_W-1:0] cnt;
  logic                cnt_clr;
  logic                cnt_en;

  // One counter times both phases; it restarts from zero whenever the state
  // changes or a user request re-enters ASSERT.
  riv_counter #(
    .WIDTH (WD_CNT_W)
  ) u_cnt (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt)
  );

  assign cnt_clr = i_user_rst_req || (state_nx != state);
  assign cnt_en  = (state == ST_ASSERT) || (state == ST_WAIT_DONE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nx = state;
    retry_nx = o_retry_count;
    fault_nx = o_fault_count;

    if (i_user_rst_req) begin
      state_nx = ST_ASSERT;
      retry_nx = '0;
    end else begin
      case (state)
        ST_WAIT_DONE: begin
          // reset_done is checked first so it wins over a coincident timeout
          if (i_reset_done) begin
            state_nx = ST_RUN;
            retry_nx = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nx = o_retry_count + 4'd1;
            state_nx = (retry_nx == RETRY_LIMIT) ? ST_FAILED : ST_ASSERT;
          end
        end
        ST_RUN: begin
          // RUN is only entered with reset_done high, so a low level here is
          // a fall of reset_done.
          if (i_link_fault || !i_reset_done) begin
            state_nx = ST_ASSERT;
            fault_nx = sat_inc8(o_fault_count);
          end
        end
        ST_FAILED: begin
          state_nx = ST_FAILED;
        end
        default: begin
          // ASSERT; the reserved code is steered back into a clean ASSERT
          if (state != ST_ASSERT) begin
            state_nx = ST_ASSERT;
          end else if (cnt == PULSE_LAST) begin
            state_nx = ST_WAIT_DONE;
          end
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state         <= ST_ASSERT;
      o_ctrl_rst_n  <= 1'b0;
      o_busy        <= 1'b1;
      o_failed      <= 1'b0;
      o_retry_count <= '0;
      o_fault_count <= '0;
    end else begin
      state         <= state_nx;
      o_ctrl_rst_n  <= (state_nx == ST_WAIT_DONE) || (state_nx == ST_RUN);
      o_busy        <= (state_nx == ST_ASSERT) || (state_nx == ST_WAIT_DONE);
      o_failed      <= (state_nx == ST_FAILED);
      o_retry_count <= retry_nx;
      o_fault_count <= fault_nx;
    end
  end

endmodule
